// File: rtl/arbitro_enrutamiento_param.sv
// Arbiter/router between NUM_VC virtual-channel FIFOs and NUM_DEST destination FIFOs.
// Each cycle, at most one eligible VC is granted. Its head word is popped
// combinationally and pushed to the destination selected by the word's destination field.
// Out-of-range destinations are drained and counted in a saturating drop counter.
module arbitro_enrutamiento_param #(
  parameter int DATA_W     = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int DEST_LSB   = 4,
  parameter int ARB_MODE   = 0,
  parameter int PAUSE_MODE = 0
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_VC*DATA_W-1:0]     vc_data,
  input  logic [NUM_VC-1:0]            vc_empty,
  output logic [NUM_VC-1:0]            vc_pop,
  input  logic [NUM_DEST-1:0]          d_pause,
  output logic [NUM_DEST*DATA_W-1:0]   d_data,
  output logic [NUM_DEST-1:0]          d_push,
  output logic [1:0]                   arb_state,
  output logic [7:0]                   drop_cnt
);

  localparam int DEST_W  = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int PTR_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int PEXT_W  = 1 << DEST_W;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_STALL  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [7:0]                   drop_q, drop_d;
  logic [NUM_DEST-1:0]          push_q, push_d;
  logic [NUM_DEST*DATA_W-1:0]   data_q, data_d;

  logic                         run;
  logic [DATA_W-1:0]            vc_word [NUM_VC];
  logic [NUM_VC-1:0]            elig;
  logic [PEXT_W-1:0]            pause_ext;
  logic                         grant_valid;
  logic [PTR_W-1:0]             grant_idx;
  logic [DATA_W-1:0]            grant_word;
  logic [DEST_W-1:0]            grant_dst;
  logic                         grant_in_range;

  assign run = (state_q != ST_RESET);

  // Pause flags padded with zeros so unreachable destination codes read as "not paused";
  // that makes out-of-range words always eligible and they get drained.
  assign pause_ext = PEXT_W'(d_pause);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign vc_word[gi] = vc_data[gi*DATA_W +: DATA_W];
      if (PAUSE_MODE == 0) begin : g_pause_all
        assign elig[gi] = run && !vc_empty[gi] && !(|pause_ext);
      end else begin : g_pause_dst
        logic [DEST_W-1:0] dst;
        assign dst      = vc_word[gi][DEST_LSB +: DEST_W];
        assign elig[gi] = run && !vc_empty[gi] && !pause_ext[dst];
      end
    end
  endgenerate

  // Grant selection: scan from index 0 (fixed) or from the RR pointer (round robin).
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = (ARB_MODE != 0) ? PTR_W'((int'(ptr_q) + k) % NUM_VC) : PTR_W'(k);
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign grant_word     = vc_word[grant_idx];
  assign grant_dst      = grant_word[DEST_LSB +: DEST_W];
  assign grant_in_range = (int'(grant_dst) < NUM_DEST);

  // Pop strobe is combinational so the FIFO advances in the same cycle as the grant.
  assign vc_pop = (reset_L && grant_valid) ? (NUM_VC'(1) << grant_idx) : '0;

  // Next-state computation: FSM, RR pointer, push lanes and drop counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = drop_q;
    push_d  = '0;
    data_d  = data_q;
    if (state_q == ST_RESET) begin
      state_d = ST_IDLE;
    end else if (grant_valid) begin
      state_d = ST_ACTIVE;
      ptr_d   = (grant_idx == PTR_W'(NUM_VC - 1)) ? '0 : grant_idx + PTR_W'(1);
      if (grant_in_range) begin
        data_d[int'(grant_dst)*DATA_W +: DATA_W] = grant_word;
        push_d[grant_dst]                        = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (|(~vc_empty)) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // All state registers; reset clears pending pushes so nothing partial reaches a destination.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      ptr_q   <= '0;
      drop_q  <= '0;
      push_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  assign d_data    = data_q;
  assign d_push    = push_q;
  assign arb_state = state_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// Bench for arbitro_enrutamiento_param. Three configurations run in lockstep:
//   cfg0: 2 VC / 2 dest, fixed priority, global pause
//   cfg1: 2 VC / 2 dest, round robin, per-destination pause
//   cfg2: 3 VC / 3 dest, round robin, per-destination pause (out-of-range dest 3)
// VC FIFOs are modelled as queues; a reference model predicts grant, pushes, state and drops.
module tb_arbitro_enrutamiento_param;

  localparam int NC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] vcd [NC];
  logic [2:0]  vce [NC];
  logic [2:0]  dp  [NC];

  logic [1:0]  pop0, pop1;
  logic [2:0]  pop2;
  logic [11:0] dd0, dd1;
  logic [17:0] dd2;
  logic [1:0]  pu0, pu1;
  logic [2:0]  pu2;
  logic [1:0]  st0, st1, st2;
  logic [7:0]  dc0, dc1, dc2;

  arbitro_enrutamiento_param #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .DEST_LSB(4),
                               .ARB_MODE(0), .PAUSE_MODE(0)) u_cfg0 (
    .clk(clk), .reset_L(rst_n), .vc_data(vcd[0][11:0]), .vc_empty(vce[0][1:0]),
    .vc_pop(pop0), .d_pause(dp[0][1:0]), .d_data(dd0), .d_push(pu0),
    .arb_state(st0), .drop_cnt(dc0));

  arbitro_enrutamiento_param #(.DATA_W(6), .NUM_VC(2), .NUM_DEST(2), .DEST_LSB(4),
                               .ARB_MODE(1), .PAUSE_MODE(1)) u_cfg1 (
    .clk(clk), .reset_L(rst_n), .vc_data(vcd[1][11:0]), .vc_empty(vce[1][1:0]),
    .vc_pop(pop1), .d_pause(dp[1][1:0]), .d_data(dd1), .d_push(pu1),
    .arb_state(st1), .drop_cnt(dc1));

  arbitro_enrutamiento_param #(.DATA_W(6), .NUM_VC(3), .NUM_DEST(3), .DEST_LSB(4),
                               .ARB_MODE(1), .PAUSE_MODE(1)) u_cfg2 (
    .clk(clk), .reset_L(rst_n), .vc_data(vcd[2]), .vc_empty(vce[2]),
    .vc_pop(pop2), .d_pause(dp[2]), .d_data(dd2), .d_push(pu2),
    .arb_state(st2), .drop_cnt(dc2));

  // Configuration lookup
  function automatic int nvc(int c);   return (c == 2) ? 3 : 2; endfunction
  function automatic int ndst(int c);  return (c == 2) ? 3 : 2; endfunction
  function automatic int dwid(int c);  return (c == 2) ? 2 : 1; endfunction
  function automatic int arbm(int c);  return (c == 0) ? 0 : 1; endfunction
  function automatic int pmode(int c); return (c == 0) ? 0 : 1; endfunction

  // Observed outputs, zero-extended
  function automatic logic [31:0] o_pop(int c);
    case (c) 0: return 32'(pop0); 1: return 32'(pop1); default: return 32'(pop2); endcase
  endfunction
  function automatic logic [31:0] o_push(int c);
    case (c) 0: return 32'(pu0); 1: return 32'(pu1); default: return 32'(pu2); endcase
  endfunction
  function automatic logic [31:0] o_st(int c);
    case (c) 0: return 32'(st0); 1: return 32'(st1); default: return 32'(st2); endcase
  endfunction
  function automatic logic [31:0] o_drop(int c);
    case (c) 0: return 32'(dc0); 1: return 32'(dc1); default: return 32'(dc2); endcase
  endfunction
  function automatic logic [31:0] o_lane(int c, int j);
    logic [17:0] v;
    case (c) 0: v = 18'(dd0); 1: v = 18'(dd1); default: v = dd2; endcase
    return 32'(v[j*6 +: 6]);
  endfunction

  // Reference model state
  logic [5:0] vq [NC][3][$];
  int         r_state [NC];
  int         r_ptr   [NC];
  int         r_drop  [NC];
  logic [5:0] r_dd    [NC][3];
  logic [2:0] r_pu    [NC];
  int         eg      [NC];
  logic [31:0] last_pop [NC];

  int compared = 0;
  int mism = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_of(int c, logic [5:0] w);
    return (int'(w) >> 4) & ((1 << dwid(c)) - 1);
  endfunction

  function automatic bit eligible(int c, int i);
    int d;
    if (vq[c][i].size() == 0) return 1'b0;
    d = dest_of(c, vq[c][i][0]);
    if (pmode(c) == 0) begin
      for (int j = 0; j < ndst(c); j++) if (dp[c][j]) return 1'b0;
      return 1'b1;
    end
    return (d >= ndst(c)) || !dp[c][d];
  endfunction

  task automatic model_grant(int c);
    int i;
    eg[c] = -1;
    if (rst_n && r_state[c] != 0) begin
      for (int k = 0; k < nvc(c); k++) begin
        i = (arbm(c) != 0) ? (r_ptr[c] + k) % nvc(c) : k;
        if (eg[c] < 0 && eligible(c, i)) eg[c] = i;
      end
    end
  endtask

  task automatic model_update(int c);
    logic [5:0] w;
    int d;
    bit any;
    if (!rst_n) begin
      r_state[c] = 0; r_ptr[c] = 0; r_drop[c] = 0; r_pu[c] = '0;
      for (int j = 0; j < 3; j++) r_dd[c][j] = '0;
      return;
    end
    r_pu[c] = '0;
    if (r_state[c] == 0) begin
      r_state[c] = 1;
    end else if (eg[c] >= 0) begin
      w = vq[c][eg[c]].pop_front();
      d = dest_of(c, w);
      if (d < ndst(c)) begin
        r_dd[c][d] = w;
        r_pu[c][d] = 1'b1;
      end else if (r_drop[c] < 255) begin
        r_drop[c]++;
      end
      r_ptr[c]   = (eg[c] + 1) % nvc(c);
      r_state[c] = 2;
    end else begin
      any = 1'b0;
      for (int i = 0; i < nvc(c); i++) if (vq[c][i].size() > 0) any = 1'b1;
      r_state[c] = any ? 3 : 1;
    end
  endtask

  // One clock: drive heads from queues, check pops before the edge, check registers after it.
  task automatic tick();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 3; i++)
        if (i < nvc(c) && vq[c][i].size() > 0) begin
          vcd[c][i*6 +: 6] = vq[c][i][0];
          vce[c][i]        = 1'b0;
        end else begin
          vcd[c][i*6 +: 6] = 6'($urandom);
          vce[c][i]        = 1'b1;
        end
    #1;
    for (int c = 0; c < NC; c++) begin
      model_grant(c);
      last_pop[c] = o_pop(c);
      check($sformatf("pop_cfg%0d", c), o_pop(c), (eg[c] < 0) ? 32'd0 : (32'd1 << eg[c]));
      model_update(c);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      check($sformatf("state_cfg%0d", c), o_st(c), 32'(r_state[c]));
      check($sformatf("push_cfg%0d", c), o_push(c), 32'(r_pu[c]));
      check($sformatf("drop_cfg%0d", c), o_drop(c), 32'(r_drop[c]));
      for (int j = 0; j < ndst(c); j++)
        check($sformatf("data_cfg%0d_lane%0d", c, j), o_lane(c, j), 32'(r_dd[c][j]));
    end
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      vcd[c] = '0; vce[c] = '1; dp[c] = '0;
      r_state[c] = 0; r_ptr[c] = 0; r_drop[c] = 0; r_pu[c] = '0; eg[c] = -1;
      last_pop[c] = '0;
      for (int j = 0; j < 3; j++) r_dd[c][j] = '0;
    end

    // 1: reset with a word waiting, then release
    rst_n = 1'b0;
    vq[0][0].push_back(6'h15);
    ticks(2);
    check("t1_reset_state", o_st(0), 32'd0);
    check("t1_reset_pop", last_pop[0], 32'd0);
    rst_n = 1'b1;
    tick();
    check("t1_idle_after_release", o_st(0), 32'd1);
    check("t1_no_pop_in_reset", last_pop[0], 32'd0);
    tick();
    check("t1_first_pop", last_pop[0], 32'd1);
    check("t1_push_dest1", o_push(0), 32'd2);
    check("t1_data_dest1", o_lane(0, 1), 32'h15);
    tick();

    // 2: fixed-priority routing
    vq[0][0].push_back(6'h05);
    vq[0][1].push_back(6'h1A);
    tick();
    check("t2_pop_vc0", last_pop[0], 32'd1);
    check("t2_push0", o_push(0), 32'd1);
    check("t2_data0", o_lane(0, 0), 32'h05);
    tick();
    check("t2_pop_vc1", last_pop[0], 32'd2);
    check("t2_push1", o_push(0), 32'd2);
    check("t2_data1", o_lane(0, 1), 32'h1A);
    tick();

    // 3: round robin alternation with both VCs loaded
    for (int k = 0; k < 5; k++) begin
      vq[1][0].push_back(6'($urandom));
      vq[1][1].push_back(6'($urandom));
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t3_rr_cycle%0d", k), last_pop[1], (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    ticks(3);

    // 4: per-destination pause blocks only VC0's dest0 words
    dp[1] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      vq[1][0].push_back(6'h00 | 6'(k));
      vq[1][1].push_back(6'h10 | 6'(k));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t4_pop_vc1_%0d", k), last_pop[1], 32'd2);
      check($sformatf("t4_active_%0d", k), o_st(1), 32'd2);
    end
    tick();
    check("t4_stall_state", o_st(1), 32'd3);
    check("t4_stall_pop", last_pop[1], 32'd0);
    dp[1] = 3'b000;
    ticks(4);

    // 5: global pause stalls everything, release resumes next cycle
    dp[0] = 3'b010;
    vq[0][0].push_back(6'h03);
    vq[0][1].push_back(6'h14);
    ticks(2);
    check("t5_stall_state", o_st(0), 32'd3);
    check("t5_stall_pop", last_pop[0], 32'd0);
    dp[0] = 3'b000;
    tick();
    check("t5_resume_pop", last_pop[0], 32'd1);
    ticks(3);

    // 6: out-of-range destination is drained and counted, saturating
    vq[2][0].push_back(6'h35);
    tick();
    check("t6_drop_pop", last_pop[2], 32'd1);
    check("t6_drop_nopush", o_push(2), 32'd0);
    check("t6_drop_one", o_drop(2), 32'd1);
    for (int k = 0; k < 300; k++)
      vq[2][$urandom_range(0, 2)].push_back(6'h30 | 6'($urandom_range(0, 15)));
    ticks(305);
    check("t6_drop_saturated", o_drop(2), 32'd255);

    // Random traffic, pauses and occasional resets on all configurations
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          int v;
          v = $urandom_range(0, nvc(c) - 1);
          if (vq[c][v].size() < 4) vq[c][v].push_back(6'($urandom));
        end
        dp[c] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < NC; c++) dp[c] = '0;
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
